// File: rtl/conv2d_stream_engine.sv
// Streaming 3x3 valid-window convolution with two line buffers and loadable kernel.
// Define CONV_RELU_EN to clamp negative saturated results to zero.
module conv2d_stream_engine #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int IMG_W  = 6,
  parameter int IMG_H  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              w_we,
  input  logic [3:0]        w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic        last_q, last_d;
  logic        run, in_hs, out_hs, win_done;
  logic        col_end, row_end;

  logic signed [DATA_W-1:0]   kern_q [9];
  logic signed [DATA_W-1:0]   lb0_q [IMG_W];
  logic signed [DATA_W-1:0]   lb1_q [IMG_W];
  logic signed [DATA_W-1:0]   win_q [9];
  logic signed [DATA_W-1:0]   win_d [9];
  logic signed [2*DATA_W-1:0] prod  [9];
  logic signed [ACC_W-1:0]    acc;
  logic [ACC_W-DATA_W:0]      acc_hi;
  logic signed [DATA_W-1:0]   sat, res;
  logic                       out_valid_q;
  logic [DATA_W-1:0]          out_data_q;

  assign run       = (state_q == S_RUN);
  assign busy      = run;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign in_ready  = run & ~last_q & ~(out_valid_q & ~out_ready);
  assign in_hs     = in_valid & in_ready;
  assign out_hs    = out_valid_q & out_ready;
  assign done      = run & out_hs & last_q;
  assign col_end   = (col_q == CW'(IMG_W - 1));
  assign row_end   = (row_q == RW'(IMG_H - 1));
  assign win_done  = in_hs & (row_q >= RW'(2)) & (col_q >= CW'(2));

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    last_d  = last_q;
    if (state_q == S_IDLE) begin
      if (start) begin
        state_d = S_RUN;
        col_d   = '0;
        row_d   = '0;
        last_d  = 1'b0;
      end
    end else begin
      if (in_hs) begin
        if (col_end) begin
          col_d = '0;
          row_d = row_end ? '0 : row_q + 1'b1;
          if (row_end) last_d = 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      if (done) state_d = S_IDLE;
    end
  end

  // Window rows: 0 = line two rows up, 1 = previous line, 2 = incoming pixel
  always_comb begin
    for (int m = 0; m < 3; m++) begin
      win_d[m*3]   = win_q[m*3+1];
      win_d[m*3+1] = win_q[m*3+2];
    end
    win_d[2] = lb1_q[col_q];
    win_d[5] = lb0_q[col_q];
    win_d[8] = in_data;
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < 9; i++) begin
      prod[i] = win_d[i] * kern_q[i];
      acc = acc + {{(ACC_W-2*DATA_W){prod[i][2*DATA_W-1]}}, prod[i]};
    end
  end

  assign acc_hi = acc[ACC_W-1:DATA_W-1];

  always_comb begin
    sat = acc[DATA_W-1:0];
    if (!((&acc_hi) || ~(|acc_hi)))
      sat = acc[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                         : {1'b0, {(DATA_W-1){1'b1}}};
  end

`ifdef CONV_RELU_EN
  assign res = sat[DATA_W-1] ? '0 : sat;
`else
  assign res = sat;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      last_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int i = 0; i < 9; i++) begin
        kern_q[i] <= '0;
        win_q[i]  <= '0;
      end
      for (int i = 0; i < IMG_W; i++) begin
        lb0_q[i] <= '0;
        lb1_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      last_q  <= last_d;
      if (!run && w_we && (w_addr <= 4'd8))
        kern_q[w_addr] <= w_data;
      if (in_hs) begin
        lb1_q[col_q] <= lb0_q[col_q];
        lb0_q[col_q] <= in_data;
        for (int i = 0; i < 9; i++) win_q[i] <= win_d[i];
      end
      if (win_done) begin
        out_valid_q <= 1'b1;
        out_data_q  <= res;
      end else if (out_hs) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Self-checking bench for conv2d_stream_engine: directed frames plus
// randomized frames compared against a direct window-sum reference model.
module tb_conv2d_stream_engine;

  localparam int DW   = 16;
  localparam int AW   = 40;
  localparam int W    = 6;
  localparam int H    = 6;
  localparam int NPIX = W * H;
  localparam int NOUT = (W - 2) * (H - 2);
  localparam longint SMAX = (64'sd1 <<< (DW - 1)) - 1;
  localparam longint SMIN = -(64'sd1 <<< (DW - 1));

  logic clk = 1'b0;
  logic rst_n, start, busy, done, w_we;
  logic [3:0] w_addr;
  logic [DW-1:0] w_data;
  logic in_valid, in_ready, out_valid, out_ready;
  logic signed [DW-1:0] in_data;
  logic signed [DW-1:0] out_data;

  int n_chk = 0;
  int n_fail = 0;
  int img [NPIX];
  int kern [9];
  longint got [$];

  conv2d_stream_engine #(
    .DATA_W(DW), .ACC_W(AW), .IMG_W(W), .IMG_H(H)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int rnd16();
    logic [15:0] t;
    t = 16'($urandom);
    return int'($signed(t));
  endfunction

  function automatic longint ref_out(input int k);
    int r0, c0;
    longint s;
    r0 = k / (W - 2);
    c0 = k % (W - 2);
    s = 0;
    for (int m = 0; m < 3; m++)
      for (int n = 0; n < 3; n++)
        s += longint'(img[(r0 + m) * W + c0 + n]) * longint'(kern[m * 3 + n]);
    if (s > SMAX) s = SMAX;
    if (s < SMIN) s = SMIN;
`ifdef CONV_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  task automatic write_kernel();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      w_we = 1'b1;
      w_addr = 4'(i);
      w_data = DW'(kern[i]);
    end
    @(negedge clk);
    w_we = 1'b0;
  endtask

  task automatic set_kernel_const(input int v);
    for (int i = 0; i < 9; i++) kern[i] = v;
    write_kernel();
  endtask

  task automatic start_frame();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_frame(input string tag, input bit rnd_in,
                           input bit rnd_out, input int hold, input bit guard);
    int idx, nout, ndone, held;
    bit holding;
    idx = 0; nout = 0; ndone = 0; held = 0;
    got.delete();
    for (int cyc = 0; cyc < 3000 && nout < NOUT; cyc++) begin
      @(negedge clk);
      holding = 1'b0;
      in_valid = (idx < NPIX) && (!rnd_in || $urandom_range(3) != 0);
      in_data = DW'((idx < NPIX) ? img[idx] : 0);
      out_ready = !rnd_out || ($urandom_range(2) != 0);
      if (hold > 0 && out_valid && nout == 0 && held < hold) begin
        out_ready = 1'b0;
        holding = 1'b1;
        held++;
        chk({tag, "_hold_data"}, longint'(out_data), ref_out(0));
      end
      if (guard) begin
        start = 1'b1;
        w_we = 1'b1;
        w_addr = 4'(cyc % 9);
        w_data = DW'(5);
      end
      #1;
      if (holding) chk({tag, "_hold_in_ready"}, longint'(in_ready), 0);
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        got.push_back(longint'(out_data));
        chk({tag, "_out"}, longint'(out_data), ref_out(nout));
        nout++;
      end
      if (done) ndone++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    w_we = 1'b0;
    out_ready = 1'b1;
    chk({tag, "_nout"}, nout, NOUT);
    chk({tag, "_npix"}, idx, NPIX);
    chk({tag, "_done_cnt"}, ndone, 1);
    chk({tag, "_held"}, held, hold);
    @(negedge clk);
    chk({tag, "_idle_busy"}, longint'(busy), 0);
    chk({tag, "_idle_done"}, longint'(done), 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; w_we = 1'b0; w_addr = '0; w_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_in_ready", longint'(in_ready), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_data", longint'(out_data), 0);
    rst_n = 1'b1;

    for (int i = 0; i < NPIX; i++) img[i] = i;
    set_kernel_const(1);
    start_frame();
    run_frame("ramp", 0, 0, 0, 0);
    chk("ramp_first", got[0], 63);
    chk("ramp_second", got[1], 72);
    chk("ramp_fifth", got[4], 117);
    chk("ramp_last", got[NOUT-1], 252);

    for (int i = 0; i < NPIX; i++) img[i] = 32767;
    start_frame();
    run_frame("sat_pos", 0, 0, 0, 0);
    chk("sat_pos_first", got[0], 32767);
    set_kernel_const(-1);
    start_frame();
    run_frame("sat_neg", 0, 0, 0, 0);
    chk("sat_neg_first", got[0], -32768);

    for (int i = 0; i < NPIX; i++) img[i] = 1;
    start_frame();
    run_frame("relu", 0, 0, 0, 0);
`ifdef CONV_RELU_EN
    chk("relu_first", got[0], 0);
`else
    chk("relu_first", got[0], -9);
`endif

    for (int i = 0; i < NPIX; i++) img[i] = i;
    set_kernel_const(1);
    start_frame();
    run_frame("bp", 0, 0, 10, 0);

    @(negedge clk);
    w_we = 1'b1; w_addr = 4'd12; w_data = DW'(5);
    @(negedge clk);
    w_we = 1'b0;
    in_valid = 1'b1;
    in_data = DW'(7);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("idle_in_ready", longint'(in_ready), 0);
    end
    in_valid = 1'b0;
    start_frame();
    run_frame("guard", 0, 0, 0, 1);
    chk("guard_first", got[0], 63);

    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 9; i++)
        kern[i] = (f == 0) ? int'($urandom_range(16)) - 8 : rnd16();
      for (int i = 0; i < NPIX; i++)
        img[i] = (f == 2) ? rnd16() : int'($urandom_range(400)) - 200;
      write_kernel();
      start_frame();
      run_frame($sformatf("rand%0d", f), 1, 1, 0, 0);
    end

    for (int i = 0; i < NPIX; i++) img[i] = i;
    set_kernel_const(1);
    start_frame();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data = DW'(img[i]);
      out_ready = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_busy", longint'(busy), 0);
    chk("mid_rst_in_ready", longint'(in_ready), 0);
    chk("mid_rst_out_valid", longint'(out_valid), 0);
    chk("mid_rst_out_data", longint'(out_data), 0);
    chk("mid_rst_done", longint'(done), 0);

    for (int i = 0; i < 9; i++) kern[i] = 0;
    for (int i = 0; i < NPIX; i++) img[i] = rnd16();
    start_frame();
    run_frame("zero_kern", 0, 0, 0, 0);
    chk("zero_kern_first", got[0], 0);

    for (int i = 0; i < NPIX; i++) img[i] = i;
    set_kernel_const(1);
    start_frame();
    run_frame("reload", 0, 0, 0, 0);
    chk("reload_first", got[0], 63);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/conv2d_stream_engine.md
# conv2d_stream_engine

Streaming, clocked 3x3 2-D convolution engine: a successor to the combinational fixed-kernel convolution block. It accepts a raster-ordered pixel stream over a valid/ready handshake and buffers two image rows in line buffers. Each valid (no padding, stride 1) window result is emitted on a back-pressurable output stream. Kernel weights are runtime-loadable, and image dimensions and widths are parameters; the block sits between the input feature-map DMA and the pooling stage.

## Interface
- `DATA_W`, default 16: signed pixel, weight and output width.
- `ACC_W`, default 40: signed accumulator width. Must be ≥ 2·DATA_W+4.
- `IMG_W`, default 6: image width in pixels. Must be ≥ 3.
- `IMG_H`, default 6: image height in pixels. Must be ≥ 3.
- `clk` input, 1 bit: the single clock. All logic is on the rising edge.
- `rst_n` input, 1 bit: synchronous, active-low reset.
- `start` input, 1 bit: one-cycle pulse that begins a frame. Honoured only in IDLE.
- `busy` output, 1 bit: high in RUN.
- `done` output, 1 bit: one-cycle pulse when the frame's last output is accepted.
- `w_we` input, 1 bit: kernel weight write enable.
- `w_addr` input, 4 bits: weight index 0..8, row-major (m·3+n).
- `w_data` input, DATA_W bits: signed weight value.
- `in_valid` input, 1 bit: input pixel valid.
- `in_ready` output, 1 bit: engine can accept a pixel.
- `in_data` input, DATA_W bits: signed pixel, raster order.
- `out_valid` output, 1 bit: result valid.
- `out_ready` input, 1 bit: downstream accepts the result.
- `out_data` output, DATA_W bits: signed, saturated result.

## Operation
- **State machine:** IDLE → RUN on `start`. RUN → IDLE when the last output handshake completes, with `done` pulsed in that same cycle. There is no other state.
- **Counters:** a column counter runs 0..IMG_W-1 and a row counter runs 0..IMG_H-1. Both advance on each input handshake (`in_valid & in_ready`). Both clear on `start`.
- **Line buffers:** two IMG_W-deep row buffers plus a 3x3 window shift register, which advances by one column per accepted pixel.
- **Output generation:** the accepted pixel at (r,c) with r≥2 and c≥2 completes window top-left (r-2, c-2). The MAC computes Σ window[m][n]·kernel[m·3+n], signed, in ACC_W bits. The result is saturated to signed DATA_W range [-2^(DATA_W-1), 2^(DATA_W-1)-1] and written to the output register. All other pixels only fill the buffers.
- **Frame size:** a frame produces exactly (IMG_W-2)·(IMG_H-2) outputs, in raster order.
- **Kernel writes:** accepted only when not busy. A write while busy is ignored, and so is any `w_addr` > 8. The kernel resets to all zeros.
- **`start` while RUN:** ignored.
- **`in_valid` in IDLE:** not accepted; `in_ready` is 0.
- **Input after the frame's last pixel:** not accepted; `in_ready` drops after the IMG_W·IMG_H-th handshake.

## Timing
- **Input ready:** `in_ready` = RUN & ~last_pixel_taken & ~(`out_valid` & ~`out_ready`).
- **Output buffering:** the output register is one entry deep.
- **Latency:** one cycle. The pixel that completes a window is accepted in cycle t, and `out_valid`/`out_data` appear in cycle t+1.
- **Output hold:** `out_valid` holds and `out_data` is stable until `out_ready`. `out_valid` deasserts after the handshake unless a new result loads in the same cycle.
- **Simultaneous events:** an output handshake and a new result load in the same cycle give continuous output at one result per cycle.
- **Throughput:** one pixel per cycle with `out_ready` tied high.
- **Reset values:**
  - 0: `busy`, `done`, `in_ready`, `out_valid`, `out_data`, the counters, the line buffers and the kernel.
  - State: IDLE.
- **Reset mid-frame:** the frame is abandoned and all of the above reset values apply on the next cycle.

## Configuration
- `CONV_RELU_EN` defined: after saturation, negative results are forced to 0 (ReLU).
- `CONV_RELU_EN` undefined: the signed saturated result passes through unchanged.
- Latency is identical in both builds.

## Test plan
- **Ramp with all-ones kernel:** load all weights = 1; start; stream pixels 0..35 with `out_ready`=1. Expect 16 outputs.
  - First output = 63, second = 72, fifth (row 1) = 117, last = 252.
  - `done` pulses once, then IDLE.
- **Saturation:** all weights = 1, all pixels = 32767. Expect all 16 outputs = 32767.
  - With weights = -1, expect -32768.
- **ReLU build:** weights all -1, pixels all 1.
  - Without `CONV_RELU_EN`: 16 outputs of -9.
  - With `CONV_RELU_EN`: 16 outputs of 0.
- **Backpressure:** hold `out_ready`=0 when the first result appears. Expect:
  - `in_ready`=0 on the next cycle;
  - `out_data` held at 63 for 10 cycles;
  - on release, the remaining sequence matches the ramp test with no loss or duplication.
- **Busy and protocol guards:**
  - `w_we` with `w_data`=5 during RUN leaves results unchanged.
  - `start` during RUN is ignored.
  - `w_addr`=12 is ignored.
  - `in_valid` in IDLE never handshakes.
- **Reset mid-frame:** assert `rst_n`=0 for one cycle after 20 pixels. Expect:
  - all outputs are 0 and the state is IDLE;
  - the kernel is zero, so the reloaded ramp frame with all-ones weights yields 63 first.
